// File: rtl/pll_reset_sequencer.sv
`timescale 1ns/1ps
// pll_reset_sequencer: PLL reset/lock supervisor on refclk that releases a clean system reset only after stable lock.
// Optional build macro PLLSEQ_LOSS_FILTER_EN: lock loss in RUN must persist LOSS_FILTER cycles before re-sequencing.
module pll_reset_sequencer #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 5000000,
  parameter int LOCK_STABLE  = 50000,
  parameter int CNT_W        = 24
`ifdef PLLSEQ_LOSS_FILTER_EN
  ,
  parameter int LOSS_FILTER  = 8
`endif
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic       timeout_err,
  output logic [7:0] relock_count
);

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sync_q;
  logic             locked_s;
  logic             lock_lost;

  // pll_locked is asynchronous to refclk; only locked_s may feed decisions.
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_q   <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make both flops sample the old values, forming a real two-stage chain.
      sync_q   <= pll_locked;
      locked_s <= sync_q;
    end
  end

`ifdef PLLSEQ_LOSS_FILTER_EN
  localparam int             LF_W    = (LOSS_FILTER > 1) ? $clog2(LOSS_FILTER) : 1;
  localparam logic [LF_W-1:0] LF_LAST = LF_W'(LOSS_FILTER - 1);

  logic [LF_W-1:0] loss_cnt;

  // Loss is declared on the LOSS_FILTER-th consecutive unlocked cycle seen in RUN.
  assign lock_lost = !locked_s && (loss_cnt == LF_LAST);

  always_ff @(posedge refclk) begin
    if (rst) begin
      loss_cnt <= '0;
    end else if (state == RUN && !locked_s && !lock_lost) begin
      loss_cnt <= loss_cnt + LF_W'(1);
    end else begin
      loss_cnt <= '0;
    end
  end
`else
  assign lock_lost = !locked_s;
`endif

  // Outputs are decoded from the pre-edge state, so each lags the state register by one edge.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state        <= PLL_RST;
      cnt          <= '0;
      pll_rst      <= 1'b1;
      sys_reset    <= 1'b1;
      ready        <= 1'b0;
      timeout_err  <= 1'b0;
      relock_count <= '0;
    end else begin
      pll_rst   <= (state == PLL_RST);
      sys_reset <= (state != RUN);
      ready     <= (state == RUN);

      case (state)
        PLL_RST: begin
          if (cnt == RST_LAST) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        WAIT_LOCK: begin
          if (force_relock) begin
            state <= PLL_RST;
            cnt   <= '0;
          end else if (locked_s) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            state       <= PLL_RST;
            cnt         <= '0;
            timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        STABLE: begin
          // Any dropout restarts qualification from WAIT_LOCK with a fresh count.
          if (force_relock) begin
            state <= PLL_RST;
            cnt   <= '0;
          end else if (!locked_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RUN: begin
          if (force_relock) begin
            state <= PLL_RST;
            cnt   <= '0;
          end else if (lock_lost) begin
            state <= PLL_RST;
            cnt   <= '0;
            if (relock_count != 8'hFF) begin
              relock_count <= relock_count + 8'd1;
            end
          end
        end

        default: begin
          state <= PLL_RST;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Both resets derive from one state register, so the 16 MHz domain never leaves reset while the PLL is held.
  a_sys_reset_covers_pll_rst : assert property (
    @(posedge refclk) disable iff (rst) !(pll_rst && !sys_reset)
  );

  a_ready_is_not_reset : assert property (
    @(posedge refclk) disable iff (rst) (ready == !sys_reset)
  );

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Reset and lock supervisor for the core PLL (50 MHz refclk in, 16 MHz outclk_0 out). Runs on the free-running reference clock. Drives the PLL's rst input and consumes its locked output. Produces a clean system reset that releases only after lock has been stable for a programmed time, and re-sequences the PLL on lock loss or timeout.

Parameters:
RST_CYCLES, 16, refclk cycles pll_rst is held high per reset attempt (>=1)
LOCK_TIMEOUT, 5000000, refclk cycles allowed in WAIT_LOCK before retry (100 ms @ 50 MHz)
LOCK_STABLE, 50000, consecutive synced-locked cycles required before release (1 ms)
CNT_W, 24, width of the shared state counter; must hold max(all three) - 1

Ports:
refclk  input  1  free-running 50 MHz reference clock; sole clock of block
rst  input  1  synchronous active-high reset
pll_locked  input  1  PLL locked output; asynchronous to refclk
force_relock  input  1  single-cycle request to re-sequence PLL
pll_rst  output  1  to PLL rst input
sys_reset  output  1  active-high reset for the 16 MHz domain logic
ready  output  1  high only in RUN
timeout_err  output  1  sticky; set on any WAIT_LOCK timeout
relock_count  output  8  saturating count of lock losses seen in RUN

Behaviour:
- One clock (refclk). rst is synchronous, active-high, sampled on the refclk rising edge.
- pll_locked passes through a 2-flop synchronizer to give locked_s. All decisions use locked_s, never pll_locked directly.
- All outputs are registered.
- Reset values while rst is high: state = PLL_RST, cnt = 0, sync flops = 0, pll_rst = 1, sys_reset = 1, ready = 0, timeout_err = 0, relock_count = 0.
- PLL_RST:
  - pll_rst = 1, sys_reset = 1.
  - cnt increments each cycle.
  - When cnt == RST_CYCLES-1: go to WAIT_LOCK, clear cnt.
  - force_relock is ignored in this state.
- WAIT_LOCK:
  - pll_rst = 0, sys_reset = 1.
  - If locked_s = 1: go to STABLE, cnt = 0.
  - Else, if cnt == LOCK_TIMEOUT-1: go to PLL_RST, cnt = 0, timeout_err = 1.
  - Otherwise cnt increments.
- STABLE:
  - sys_reset = 1.
  - If locked_s = 0: go to WAIT_LOCK, cnt = 0.
  - Else, if cnt == LOCK_STABLE-1: go to RUN.
  - Otherwise cnt increments.
- RUN:
  - sys_reset = 0, ready = 1.
  - If locked_s = 0: go to PLL_RST, cnt = 0, relock_count += 1 (holds at 255).
- force_relock in WAIT_LOCK, STABLE or RUN: go to PLL_RST, cnt = 0. relock_count is not incremented. Takes priority over every other transition in those states.
- Latency: pll_locked rises and stays high with state in WAIT_LOCK → sys_reset falls exactly LOCK_STABLE+3 refclk edges after the first edge that samples pll_locked = 1.
- Lock loss in RUN → sys_reset rises 3 edges after the first edge that samples pll_locked = 0.
- Glitches of locked_s during STABLE restart the stability count from zero. There is no partial credit.
- rst asserted mid-sequence: immediate return to the reset values on the next edge. timeout_err and relock_count are cleared only by rst.
- sys_reset is never 0 while pll_rst is 1.

Optional Feature:
PLLSEQ_LOSS_FILTER_EN
- Defined: adds parameter LOSS_FILTER (default 8). In RUN, lock loss is declared only after locked_s has been 0 for LOSS_FILTER consecutive cycles; any locked_s = 1 clears the filter count. Loss-to-sys_reset latency becomes LOSS_FILTER+2 edges.
- Undefined: a single cycle of locked_s = 0 in RUN triggers re-sequencing, as above.

Test Plan:
Bench parameters for all scenarios: RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=10.
1. Release rst; raise pll_locked 5 cycles after pll_rst falls → pll_rst high exactly 4 cycles; sys_reset falls 13 edges after locked is sampled high; ready = 1; timeout_err = 0.
2. Hold pll_locked = 0 → pll_rst re-pulses every 24 cycles (4 + 20); timeout_err sets after the first timeout and stays set.
3. In RUN, drop pll_locked for 1 cycle → sys_reset = 1 three edges later; relock_count = 1; full sequence repeats. Repeat 300 times → relock_count saturates at 255.
4. In STABLE, glitch pll_locked low at cnt = 7 → return to WAIT_LOCK; release needs 10 fresh stable cycles.
5. Pulse force_relock in RUN → PLL_RST next edge; relock_count unchanged. Pulse it during PLL_RST → no effect.
6. Assert rst mid-STABLE, and separately with timeout_err = 1 and relock_count = 3 → all outputs return to reset values on the next edge. With PLLSEQ_LOSS_FILTER_EN defined, a 7-cycle low in RUN is ignored and an 8-cycle low triggers re-sequencing.
